// File: rtl/tlul_pkg.sv
// Minimal TL-UL channel types shared by the RACL range gate and its bench.
// Only the fields the gate inspects or regenerates are modelled.
package tlul_pkg;

  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int TL_SZW = 2;
  localparam int TL_DBW = 4;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  // rsvd carries the RACL role in its LSBs with the CTN UID above it
  typedef struct packed {
    logic [4:0] rsvd;
    logic [3:0] instr_type;
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;

  typedef struct packed {
    logic [6:0] rsp_intg;
    logic [6:0] data_intg;
  } tl_d_user_t;

  typedef struct packed {
    logic                a_valid;
    tl_a_op_e            a_opcode;
    logic [2:0]          a_param;
    logic [TL_SZW-1:0]   a_size;
    logic [TL_AIW-1:0]   a_source;
    logic [TL_AW-1:0]    a_address;
    logic [TL_DBW-1:0]   a_mask;
    logic [TL_DW-1:0]    a_data;
    tl_a_user_t          a_user;
    logic                d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic                d_valid;
    tl_d_op_e            d_opcode;
    logic [2:0]          d_param;
    logic [TL_SZW-1:0]   d_size;
    logic [TL_AIW-1:0]   d_source;
    logic [TL_DIW-1:0]   d_sink;
    logic [TL_DW-1:0]    d_data;
    tl_d_user_t          d_user;
    logic                d_error;
    logic                a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_racl_range_gate.sv
// RACL gate on one TL-UL link: range-based role check on every A request;
// denied requests are answered locally with an error, logged and counted.
//
// state   | meaning
// StIdle  | channels pass through; a denied request is absorbed here
// StRsp   | error response driven to host; A and device D stalled
module tlul_racl_range_gate
  import tlul_pkg::*;
#(
  parameter int NumRanges        = 4,
  parameter int NrPolicies       = 4,
  parameter int NrRoleBits       = 2,
  parameter int NrUidBits        = 2,
  parameter int DefaultPolicySel = 0,
  parameter int CntW             = 16,
  localparam int PolSelW  = (NrPolicies > 1) ? $clog2(NrPolicies) : 1,
  localparam int RoleVecW = 2 ** NrRoleBits,
  localparam int PolW     = 2 * RoleVecW,
  localparam int RangeW   = 2 * TL_AW + PolSelW + 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  tl_h2d_t                    tl_h_i,
  output tl_d2h_t                    tl_h_o,
  output tl_h2d_t                    tl_d_o,
  input  tl_d2h_t                    tl_d_i,
  input  logic [NrPolicies*PolW-1:0] policies_i,
  input  logic [NumRanges*RangeW-1:0] ranges_i,
  input  logic                       log_clear_i,
  output logic                       racl_error_o,
  output logic                       err_valid_o,
  output logic                       err_overflow_o,
  output logic [NrRoleBits-1:0]      err_role_o,
  output logic [NrUidBits-1:0]       err_uid_o,
  output logic                       err_read_o,
  output logic [TL_AW-1:0]           err_addr_o,
  output logic [CntW-1:0]            deny_cnt_o
);

  typedef enum logic {StIdle, StRsp} state_e;

  state_e                state_q, state_d;
  logic                  is_read, allow, denied_hs;
  logic [NrRoleBits-1:0] role;
  logic [NrUidBits-1:0]  uid;
  logic [TL_AIW-1:0]     rsp_source_q;
  logic [TL_SZW-1:0]     rsp_size_q;
  logic                  rsp_read_q;

  assign is_read = (tl_h_i.a_opcode == Get);
  assign role    = tl_h_i.a_user.rsvd[NrRoleBits-1:0];
  assign uid     = tl_h_i.a_user.rsvd[NrRoleBits+NrUidBits-1:NrRoleBits];

  // Descending scan so the lowest matching range is the one left in sel
  always_comb begin
    int                  sel;
    logic [RangeW-1:0]   rng;
    logic [TL_AW-1:0]    base, limit;
    logic [PolW-1:0]     pol;
    logic                pol_hit;
    logic [RoleVecW-1:0] read_perm, write_perm;
    sel     = DefaultPolicySel;
    rng     = '0;
    base    = '0;
    limit   = '0;
    pol     = '0;
    pol_hit = 1'b0;
    for (int i = NumRanges - 1; i >= 0; i--) begin
      rng   = ranges_i[i*RangeW +: RangeW];
      base  = rng[RangeW-1 -: TL_AW];
      limit = rng[PolSelW+1 +: TL_AW];
      if (rng[0] && (tl_h_i.a_address >= base) && (tl_h_i.a_address <= limit)) begin
        sel = int'(rng[PolSelW:1]);
      end
    end
    // A selector naming no existing policy leaves pol_hit low and denies
    for (int p = 0; p < NrPolicies; p++) begin
      if (sel == p) begin
        pol     = policies_i[p*PolW +: PolW];
        pol_hit = 1'b1;
      end
    end
    read_perm  = pol[RoleVecW-1:0];
    write_perm = pol[PolW-1:RoleVecW];
    allow      = pol_hit && (is_read ? read_perm[role] : write_perm[role]);
  end

  assign denied_hs = (state_q == StIdle) && tl_h_i.a_valid && !allow;

  always_comb begin
    state_d = state_q;
    tl_d_o  = tl_h_i;
    tl_h_o  = tl_d_i;
    unique case (state_q)
      StIdle: begin
        if (tl_h_i.a_valid && !allow) begin
          tl_d_o.a_valid = 1'b0;
          tl_h_o.a_ready = 1'b1;
          state_d        = StRsp;
        end
      end
      StRsp: begin
        tl_d_o.a_valid  = 1'b0;
        tl_d_o.d_ready  = 1'b0;
        tl_h_o.a_ready  = 1'b0;
        tl_h_o.d_valid  = 1'b1;
        tl_h_o.d_opcode = rsp_read_q ? AccessAckData : AccessAck;
        tl_h_o.d_param  = '0;
        tl_h_o.d_size   = rsp_size_q;
        tl_h_o.d_source = rsp_source_q;
        tl_h_o.d_sink   = '0;
        tl_h_o.d_data   = '0;
        tl_h_o.d_user   = '0;
        tl_h_o.d_error  = 1'b1;
        if (tl_h_i.d_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      rsp_source_q <= '0;
      rsp_size_q   <= '0;
      rsp_read_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (denied_hs) begin
        rsp_source_q <= tl_h_i.a_source;
        rsp_size_q   <= tl_h_i.a_size;
        rsp_read_q   <= is_read;
      end
    end
  end

  // A clear in the same cycle as a denial still lets that denial be captured
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      racl_error_o   <= 1'b0;
      err_valid_o    <= 1'b0;
      err_overflow_o <= 1'b0;
      err_role_o     <= '0;
      err_uid_o      <= '0;
      err_read_o     <= 1'b0;
      err_addr_o     <= '0;
      deny_cnt_o     <= '0;
    end else begin
      racl_error_o <= denied_hs;
      if (log_clear_i) begin
        err_valid_o    <= 1'b0;
        err_overflow_o <= 1'b0;
      end
      if (denied_hs) begin
        if (!err_valid_o || log_clear_i) begin
          err_valid_o <= 1'b1;
          err_role_o  <= role;
          err_uid_o   <= uid;
          err_read_o  <= is_read;
          err_addr_o  <= tl_h_i.a_address;
        end else begin
          err_overflow_o <= 1'b1;
        end
        if (deny_cnt_o != {CntW{1'b1}}) deny_cnt_o <= deny_cnt_o + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tlul_racl_range_gate.sv
// Bench for tlul_racl_range_gate: directed scenarios plus random traffic,
// checked every cycle against a table-driven model of the RACL rules.
module tb_tlul_racl_range_gate;
  import tlul_pkg::*;

  localparam int NR  = 4;
  localparam int NP  = 4;
  localparam int RB  = 2;
  localparam int UB  = 2;
  localparam int RVW = 4;
  localparam int PSW = 2;
  localparam int RW  = 2 * TL_AW + PSW + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  tl_h2d_t h_i, d_o, s_d_o;
  tl_d2h_t d_i, h_o, s_h_o;
  logic [NP*2*RVW-1:0] policies;
  logic [NR*RW-1:0]    ranges;
  logic                log_clear;

  logic             racl_error, err_valid, err_overflow, err_read;
  logic [RB-1:0]    err_role;
  logic [UB-1:0]    err_uid;
  logic [TL_AW-1:0] err_addr;
  logic [15:0]      deny_cnt;
  logic             s_racl_error, s_err_valid, s_err_overflow, s_err_read;
  logic [RB-1:0]    s_err_role;
  logic [UB-1:0]    s_err_uid;
  logic [TL_AW-1:0] s_err_addr;
  logic [1:0]       s_deny_cnt;

  // configuration tables
  logic [TL_AW-1:0] c_base [NR];
  logic [TL_AW-1:0] c_limit[NR];
  logic [PSW-1:0]   c_psel [NR];
  logic             c_en   [NR];
  logic [RVW-1:0]   p_rd   [NP];
  logic [RVW-1:0]   p_wr   [NP];

  always_comb begin
    ranges   = '0;
    policies = '0;
    for (int i = 0; i < NR; i++) ranges[i*RW +: RW] = {c_base[i], c_limit[i], c_psel[i], c_en[i]};
    for (int p = 0; p < NP; p++) policies[p*2*RVW +: 2*RVW] = {p_wr[p], p_rd[p]};
  end

  tlul_racl_range_gate #(.NumRanges(NR), .NrPolicies(NP), .NrRoleBits(RB), .NrUidBits(UB),
                         .DefaultPolicySel(0), .CntW(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .tl_h_i(h_i), .tl_h_o(h_o), .tl_d_o(d_o), .tl_d_i(d_i),
    .policies_i(policies), .ranges_i(ranges), .log_clear_i(log_clear),
    .racl_error_o(racl_error), .err_valid_o(err_valid), .err_overflow_o(err_overflow),
    .err_role_o(err_role), .err_uid_o(err_uid), .err_read_o(err_read),
    .err_addr_o(err_addr), .deny_cnt_o(deny_cnt));

  tlul_racl_range_gate #(.NumRanges(NR), .NrPolicies(NP), .NrRoleBits(RB), .NrUidBits(UB),
                         .DefaultPolicySel(0), .CntW(2)) dut_sat (
    .clk_i(clk), .rst_ni(rst_n), .tl_h_i(h_i), .tl_h_o(s_h_o), .tl_d_o(s_d_o), .tl_d_i(d_i),
    .policies_i(policies), .ranges_i(ranges), .log_clear_i(log_clear),
    .racl_error_o(s_racl_error), .err_valid_o(s_err_valid), .err_overflow_o(s_err_overflow),
    .err_role_o(s_err_role), .err_uid_o(s_err_uid), .err_read_o(s_err_read),
    .err_addr_o(s_err_addr), .deny_cnt_o(s_deny_cnt));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_pend = 0, m_read = 0, m_err = 0, m_ev = 0, m_ovf = 0, m_rd_log = 0;
  logic [7:0]  m_src = '0;
  logic [1:0]  m_size = '0, m_role = '0, m_uid = '0;
  logic [31:0] m_addr = '0;
  int          m_cnt = 0, m_scnt = 0;

  function automatic bit m_allowed(logic [31:0] addr, tl_a_op_e op, logic [1:0] role);
    int sel = 0;
    for (int i = 0; i < NR; i++) begin
      if (c_en[i] && addr >= c_base[i] && addr <= c_limit[i]) begin
        sel = int'(c_psel[i]);
        break;
      end
    end
    if (sel >= NP) return 1'b0;
    return (op == Get) ? p_rd[sel][role] : p_wr[sel][role];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend = 0; m_read = 0; m_err = 0; m_ev = 0; m_ovf = 0; m_rd_log = 0;
      m_src = '0; m_size = '0; m_role = '0; m_uid = '0; m_addr = '0;
      m_cnt = 0; m_scnt = 0;
    end else begin
      bit deny;
      deny  = !m_pend && h_i.a_valid &&
              !m_allowed(h_i.a_address, h_i.a_opcode, h_i.a_user.rsvd[1:0]);
      m_err = deny;
      if (m_pend && h_i.d_ready) m_pend = 0;
      if (deny) begin
        m_pend = 1;
        m_src  = h_i.a_source;
        m_size = h_i.a_size;
        m_read = (h_i.a_opcode == Get);
      end
      if (log_clear) begin
        m_ev  = 0;
        m_ovf = 0;
      end
      if (deny) begin
        if (!m_ev) begin
          m_ev = 1; m_role = h_i.a_user.rsvd[1:0]; m_uid = h_i.a_user.rsvd[3:2];
          m_rd_log = (h_i.a_opcode == Get); m_addr = h_i.a_address;
        end else begin
          m_ovf = 1;
        end
        if (m_cnt < 65535) m_cnt++;
        if (m_scnt < 3) m_scnt++;
      end
    end
  end

  always @(negedge clk) begin
    tl_h2d_t ed;
    tl_d2h_t eh;
    ed = h_i;
    eh = d_i;
    if (m_pend) begin
      ed.a_valid = 1'b0; ed.d_ready = 1'b0;
      eh = '0;
      eh.d_valid  = 1'b1;
      eh.d_opcode = m_read ? AccessAckData : AccessAck;
      eh.d_size   = m_size;
      eh.d_source = m_src;
      eh.d_error  = 1'b1;
    end else if (h_i.a_valid && !m_allowed(h_i.a_address, h_i.a_opcode, h_i.a_user.rsvd[1:0])) begin
      ed.a_valid = 1'b0;
      eh.a_ready = 1'b1;
    end
    chk("dev_req",      128'(d_o), 128'(ed));
    chk("host_rsp",     128'(h_o), 128'(eh));
    chk("sat_dev_req",  128'(s_d_o), 128'(ed));
    chk("sat_host_rsp", 128'(s_h_o), 128'(eh));
    chk("racl_error",   128'(racl_error), 128'(m_err));
    chk("err_valid",    128'(err_valid), 128'(m_ev));
    chk("err_overflow", 128'(err_overflow), 128'(m_ovf));
    if (m_ev) begin
      chk("err_role", 128'(err_role), 128'(m_role));
      chk("err_uid",  128'(err_uid), 128'(m_uid));
      chk("err_read", 128'(err_read), 128'(m_rd_log));
      chk("err_addr", 128'(err_addr), 128'(m_addr));
    end
    chk("deny_cnt",     128'(deny_cnt), 128'(m_cnt));
    chk("sat_deny_cnt", 128'(s_deny_cnt), 128'(m_scnt));
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    h_i = '0;
    h_i.d_ready = 1'b1;
    d_i = '0;
    d_i.a_ready = 1'b1;
  endtask

  task automatic req(input tl_a_op_e op, input logic [31:0] addr, input logic [1:0] role,
                     input logic [7:0] src);
    h_i.a_valid   = 1'b1;
    h_i.a_opcode  = op;
    h_i.a_param   = '0;
    h_i.a_size    = 2'd2;
    h_i.a_source  = src;
    h_i.a_address = addr;
    h_i.a_mask    = 4'hF;
    h_i.a_data    = 32'h1122_3344;
    h_i.a_user    = '0;
    h_i.a_user.rsvd = {1'b0, 2'b10, role};
  endtask

  initial begin
    logic [31:0] rv, rv2, rv3, addr;
    int k;
    c_base[0] = 32'h1000; c_limit[0] = 32'h1FFF; c_psel[0] = 2'd1; c_en[0] = 1'b1;
    c_base[1] = 32'h2000; c_limit[1] = 32'h2FFF; c_psel[1] = 2'd2; c_en[1] = 1'b1;
    c_base[2] = 32'h8000; c_limit[2] = 32'h9FFF; c_psel[2] = 2'd3; c_en[2] = 1'b0;
    c_base[3] = 32'hA000; c_limit[3] = 32'hAFFF; c_psel[3] = 2'd3; c_en[3] = 1'b1;
    p_rd[0] = 4'b0100; p_wr[0] = 4'b0001;
    p_rd[1] = 4'b0010; p_wr[1] = 4'b0000;
    p_rd[2] = 4'b1111; p_wr[2] = 4'b1111;
    p_rd[3] = 4'b1010; p_wr[3] = 4'b0101;
    idle_in();
    log_clear = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cnt",     128'(deny_cnt), 128'h0);
    chk("rst_valid",   128'(err_valid), 128'h0);
    chk("rst_error",   128'(racl_error), 128'h0);
    chk("rst_dvalid",  128'(h_o.d_valid), 128'h0);
    chk("rst_avalid",  128'(d_o.a_valid), 128'h0);
    #2 rst_n = 1'b1;
    step();

    // allowed read passes through in the same cycle
    req(Get, 32'h1800, 2'd1, 8'h21);
    @(negedge clk);
    chk("t1_fwd_valid", 128'(d_o.a_valid), 128'h1);
    chk("t1_fwd_addr",  128'(d_o.a_address), 128'h1800);
    chk("t1_a_ready",   128'(h_o.a_ready), 128'h1);
    step(); idle_in();
    @(negedge clk);
    chk("t1_no_err", 128'(racl_error), 128'h0);
    chk("t1_cnt",    128'(deny_cnt), 128'h0);
    step();

    // denied write answered locally one cycle later
    req(PutFullData, 32'h1800, 2'd1, 8'h5A);
    @(negedge clk);
    chk("t2_blocked", 128'(d_o.a_valid), 128'h0);
    chk("t2_a_ready", 128'(h_o.a_ready), 128'h1);
    step(); idle_in();
    @(negedge clk);
    chk("t2_dvalid", 128'(h_o.d_valid), 128'h1);
    chk("t2_derror", 128'(h_o.d_error), 128'h1);
    chk("t2_dop",    128'(h_o.d_opcode), 128'(AccessAck));
    chk("t2_dsrc",   128'(h_o.d_source), 128'h5A);
    chk("t2_pulse",  128'(racl_error), 128'h1);
    chk("t2_evalid", 128'(err_valid), 128'h1);
    chk("t2_eaddr",  128'(err_addr), 128'h1800);
    chk("t2_eread",  128'(err_read), 128'h0);
    chk("t2_cnt",    128'(deny_cnt), 128'h1);
    step();
    @(negedge clk);
    chk("t2_rsp_done", 128'(h_o.d_valid), 128'h0);

    // overlap: range 0 wins at 0x2000; 0x9000 falls to the default policy
    c_limit[0] = 32'h2000;
    req(PutFullData, 32'h2000, 2'd1, 8'h01);
    @(negedge clk);
    chk("t3_r0_wins", 128'(d_o.a_valid), 128'h0);
    step(); idle_in(); step();
    req(PutFullData, 32'h2004, 2'd1, 8'h02);
    @(negedge clk);
    chk("t3_r1_allow", 128'(d_o.a_valid), 128'h1);
    step();
    req(Get, 32'h9000, 2'd2, 8'h03);
    @(negedge clk);
    chk("t3_dflt_rd", 128'(d_o.a_valid), 128'h1);
    step();
    req(PutFullData, 32'h9000, 2'd2, 8'h04);
    @(negedge clk);
    chk("t3_dflt_wr", 128'(d_o.a_valid), 128'h0);
    step(); idle_in(); step();

    // overflow, then clear coinciding with a new denial
    log_clear = 1'b1; step(); log_clear = 1'b0;
    req(PutFullData, 32'h1800, 2'd1, 8'h05); step(); idle_in(); step();
    req(PutFullData, 32'h2000, 2'd1, 8'h06); step(); idle_in();
    @(negedge clk);
    chk("t4_ovf",   128'(err_overflow), 128'h1);
    chk("t4_first", 128'(err_addr), 128'h1800);
    step();
    req(PutFullData, 32'h9000, 2'd2, 8'h07);
    log_clear = 1'b1; step(); log_clear = 1'b0; idle_in();
    @(negedge clk);
    chk("t4_valid",   128'(err_valid), 128'h1);
    chk("t4_ovf_clr", 128'(err_overflow), 128'h0);
    chk("t4_addr",    128'(err_addr), 128'h9000);
    chk("t4_role",    128'(err_role), 128'h2);
    chk("t4_cnt",     128'(deny_cnt), 128'h6);
    chk("t4_sat",     128'(s_deny_cnt), 128'h3);
    step();

    // host back-pressure during the error response
    req(PutFullData, 32'h1800, 2'd1, 8'h33);
    step();
    req(Get, 32'h9000, 2'd2, 8'h08);
    h_i.d_ready = 1'b0;
    d_i.d_valid = 1'b1; d_i.d_opcode = AccessAckData; d_i.d_data = 32'hCAFE; d_i.d_source = 8'h44;
    repeat (5) begin
      @(negedge clk);
      chk("t5_dvalid",   128'(h_o.d_valid), 128'h1);
      chk("t5_derror",   128'(h_o.d_error), 128'h1);
      chk("t5_dsrc",     128'(h_o.d_source), 128'h33);
      chk("t5_ddata",    128'(h_o.d_data), 128'h0);
      chk("t5_dev_rdy",  128'(d_o.d_ready), 128'h0);
      chk("t5_a_stall",  128'(h_o.a_ready), 128'h0);
      chk("t5_a_block",  128'(d_o.a_valid), 128'h0);
      step();
    end
    h_i.d_ready = 1'b1;
    @(negedge clk);
    chk("t5_last_rsp", 128'(h_o.d_source), 128'h33);
    step();
    @(negedge clk);
    chk("t5_dev_rsp",   128'(h_o.d_data), 128'hCAFE);
    chk("t5_dev_noerr", 128'(h_o.d_error), 128'h0);
    chk("t5_a_fwd",     128'(d_o.a_valid), 128'h1);
    chk("t5_dev_rdy1",  128'(d_o.d_ready), 128'h1);
    step(); idle_in();

    // reset while the error response is pending
    req(PutFullData, 32'h1800, 2'd1, 8'h09);
    step(); idle_in(); h_i.d_ready = 1'b0;
    @(negedge clk);
    chk("t6_pre_rsp", 128'(h_o.d_valid), 128'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_dvalid", 128'(h_o.d_valid), 128'h0);
    chk("t6_cnt",    128'(deny_cnt), 128'h0);
    chk("t6_scnt",   128'(s_deny_cnt), 128'h0);
    chk("t6_valid",  128'(err_valid), 128'h0);
    chk("t6_error",  128'(racl_error), 128'h0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    step(); idle_in();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      rv = $urandom; rv2 = $urandom; rv3 = $urandom;
      if (n % 250 == 0) begin
        for (int i = 0; i < NR; i++) begin
          c_en[i]   = rv[i];
          c_psel[i] = rv[2*i+4 +: 2];
        end
        for (int p = 0; p < NP; p++) begin
          p_rd[p] = rv3[4*p +: 4];
          p_wr[p] = rv3[16+4*p +: 4];
        end
        rv3 = $urandom;
      end
      k = int'(rv2[17:16]);
      case (rv2[19:18])
        2'd0:    addr = c_base[k];
        2'd1:    addr = c_limit[k];
        2'd2:    addr = c_limit[k] + 32'd1;
        default: addr = c_base[k] - 32'd1;
      endcase
      if (rv2[20]) addr = {16'h0, rv3[15:0]};
      h_i.a_valid   = rv[0] | rv[1];
      case (rv[3:2])
        2'd2:    h_i.a_opcode = PutFullData;
        2'd3:    h_i.a_opcode = PutPartialData;
        default: h_i.a_opcode = Get;
      endcase
      h_i.a_address   = addr;
      h_i.a_user.rsvd = rv2[4:0];
      h_i.a_source    = rv2[12:5];
      h_i.a_size      = rv2[14:13];
      h_i.a_data      = rv3;
      h_i.d_ready     = rv[4] | rv[5];
      d_i.d_valid     = rv[6];
      d_i.d_opcode    = rv[7] ? AccessAckData : AccessAck;
      d_i.d_source    = rv[15:8];
      d_i.d_error     = rv[16];
      d_i.a_ready     = rv[17] | rv[18];
      d_i.d_size      = rv[20:19];
      d_i.d_data      = $urandom;
      log_clear       = (rv[24:21] == 4'd0);
      step();
    end
    idle_in();
    log_clear = 1'b0;
    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
